// File: rtl/sram_slave_resp_pkg.sv
// Shared bus package for the SRAM-style slave and its initiators.
// Holds the transfer-size encoding, the reserved-size mapping, the byte-enable
// function and the response-entry layout used by the response FIFO.
package sram_slave_resp_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2,
    SizeRsvd = 2'd3
  } size_e;

  localparam int unsigned DataW = 32;
  // Wide enough for the largest supported wait count (7).
  localparam int unsigned CntW  = 3;

  // cnt sits in the low bits so the FIFO can count it down generically.
  typedef struct packed {
    logic             is_write;
    logic [DataW-1:0] data;
    logic [CntW-1:0]  cnt;
  } resp_entry_t;

  localparam int unsigned EntryW = $bits(resp_entry_t);

  // The reserved encoding behaves as a full word.
  function automatic size_e norm_size(input logic [1:0] size);
    return (size == SizeRsvd) ? SizeWord : size_e'(size);
  endfunction

  // Byte-lane enables; misaligned halves/words silently ignore the low bits.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (norm_size(size))
      SizeByte: be = 4'b0001 << addr_lo;
      SizeHalf: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_slave_resp_if.sv
// Request/response bus between an initiator and the SRAM slave.
// master: drives req, wr, size, addr, wdata; sees addr_ok, data_ok, rdata.
// slave:  the reverse.
interface sram_slave_resp_if;
  import sram_slave_resp_pkg::*;

  logic             req;
  logic             wr;
  logic [1:0]       size;
  logic [31:0]      addr;
  logic [DataW-1:0] wdata;
  logic             addr_ok;
  logic             data_ok;
  logic [DataW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_slave_resp_resp_fifo.sv
// In-order response FIFO whose entries carry a wait counter in their low CntW
// bits. Every valid entry with a nonzero counter counts down once per cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to store
//   pop        : drop the head entry
//   head_valid : head slot holds an entry
//   head_data  : head entry contents
module resp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 36,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [Width-1:0] head_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q   [Depth];
  logic [Width-1:0] mem_d   [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i] && (mem_q[i][CntW-1:0] != '0)) begin
        mem_d[i][CntW-1:0] = mem_q[i][CntW-1:0] - 1'b1;
      end
    end
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = ptr_inc(rptr_q);
    end
    // The tail slot is always free when pushing: upstream never exceeds Depth.
    if (push) begin
      mem_d[wptr_q]   = push_data;
      valid_d[wptr_q] = 1'b1;
      wptr_d          = ptr_inc(wptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Payload needs no reset; valid bits gate it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid = valid_q[rptr_q];
  assign head_data  = mem_q[rptr_q];

endmodule

// File: rtl/sram_slave_resp.sv
// SRAM slave response logic: accepts bus requests, drives a synchronous RAM
// in the accept cycle, captures the RAM result one cycle later into an
// in-order response FIFO and returns it after WAIT extra cycles.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : slave side of the request/response bus
//   ram_en     : RAM enable (equals addr_ok)
//   ram_we     : RAM byte write enables
//   ram_addr   : RAM word address, addr[RAM_AW+1:2]
//   ram_wdata  : RAM write data, equals bus wdata
//   ram_rdata  : RAM read data, valid one cycle after ram_en
module sram_slave_resp
  import sram_slave_resp_pkg::*;
#(
  parameter int unsigned RAM_AW = 14,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_slave_resp_if.slave  bus,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DataW-1:0]  ram_wdata,
  input  logic [DataW-1:0]  ram_rdata
);

  // Outstanding = accepted-but-not-captured plus FIFO entries; never above 4.
  logic [2:0]        count_q, count_d;
  logic              pend_q;
  logic              pend_wr_q;
  logic              accept;
  logic              pop;
  logic              head_valid;
  logic [EntryW-1:0] head_raw;
  resp_entry_t       head;
  resp_entry_t       push_entry;
  logic              unused_bits;

  // No full-bypass: a pop in the same cycle does not free a slot early.
  assign accept = bus.req && !rst && (count_q < 3'(DEPTH));
  assign head   = resp_entry_t'(head_raw);
  assign pop    = head_valid && (head.cnt == '0) && !rst;

  assign bus.addr_ok = accept;
  assign bus.data_ok = pop;
  assign bus.rdata   = pop ? head.data : '0;

  assign ram_en    = accept;
  assign ram_we    = (accept && bus.wr) ? byte_en(bus.size, bus.addr[1:0]) : 4'b0000;
  assign ram_addr  = bus.addr[RAM_AW+1:2];
  assign ram_wdata = bus.wdata;

  always_comb begin
    push_entry.is_write = pend_wr_q;
    push_entry.data     = pend_wr_q ? '0 : ram_rdata;
    push_entry.cnt      = CntW'(WAIT);
  end

  always_comb begin
    count_d = count_q + {2'b00, accept} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pend_q    <= accept;
      pend_wr_q <= bus.wr;
    end
  end

  resp_fifo #(
    .Depth (DEPTH),
    .Width (EntryW),
    .CntW  (CntW)
  ) u_resp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pend_q),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_raw)
  );

  assign unused_bits = ^{bus.addr[31:RAM_AW+2], head.is_write};

endmodule

// File: tb/tb_sram_slave_resp.sv
module tb_sram_slave_resp;

  localparam int unsigned RamAw = 14;
  localparam int          Depth = 2;

  logic        clk = 1'b0;
  logic        rst, req, wr, tb_init;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  always #5 clk = ~clk;

  sram_slave_resp_if bus0 ();
  sram_slave_resp_if bus3 ();

  assign bus0.req = req;   assign bus3.req = req;
  assign bus0.wr = wr;     assign bus3.wr = wr;
  assign bus0.size = size; assign bus3.size = size;
  assign bus0.addr = addr; assign bus3.addr = addr;
  assign bus0.wdata = wdata; assign bus3.wdata = wdata;

  // Index 0: WAIT=0 instance, index 1: WAIT=3 instance.
  logic             en_a   [2];
  logic [3:0]       we_a   [2];
  logic [RamAw-1:0] ra_a   [2];
  logic [31:0]      wd_a   [2];
  logic [31:0]      rd_a   [2];
  logic             aok_a  [2];
  logic             dok_a  [2];
  logic [31:0]      rdat_a [2];

  assign aok_a[0] = bus0.addr_ok; assign dok_a[0] = bus0.data_ok; assign rdat_a[0] = bus0.rdata;
  assign aok_a[1] = bus3.addr_ok; assign dok_a[1] = bus3.data_ok; assign rdat_a[1] = bus3.rdata;

  sram_slave_resp #(.RAM_AW(RamAw), .DEPTH(Depth), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ram_en(en_a[0]), .ram_we(we_a[0]),
    .ram_addr(ra_a[0]), .ram_wdata(wd_a[0]), .ram_rdata(rd_a[0])
  );

  sram_slave_resp #(.RAM_AW(RamAw), .DEPTH(Depth), .WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .ram_en(en_a[1]), .ram_we(we_a[1]),
    .ram_addr(ra_a[1]), .ram_wdata(wd_a[1]), .ram_rdata(rd_a[1])
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 | (32'(i) * 32'h0001_0203));
  endfunction

  // Synchronous RAM stubs, one per instance, 64 words.
  logic [31:0] ram_m [2][64];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tb_init) begin
        for (int i = 0; i < 64; i++) ram_m[k][i] <= init_word(i);
      end else if (en_a[k]) begin
        rd_a[k] <= ram_m[k][ra_a[k][5:0]];
        for (int b = 0; b < 4; b++)
          if (we_a[k][b]) ram_m[k][ra_a[k][5:0]][8*b +: 8] <= wd_a[k][8*b +: 8];
      end
    end
  end

  // Reference model: expected responses due at accept + 2 + WAIT, in order.
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_m [2][64];
  exp_t        rb [2][16];
  int          hd [2];
  int          tl [2];
  logic        exp_acc [2];
  logic        exp_pop [2];
  int          cyc;
  int          checks;
  int          errors;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] s, input logic [1:0] lo);
    case (s)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      int          outst;
      logic [31:0] exp_rd;
      outst      = tl[k] - hd[k];
      exp_acc[k] = req && !rst && (outst < Depth);
      exp_pop[k] = !rst && (outst > 0) && (rb[k][hd[k] % 16].due == cyc);
      exp_rd     = exp_pop[k] ? rb[k][hd[k] % 16].data : 32'h0;
      chk("addr_ok", k, 32'(aok_a[k]), 32'(exp_acc[k]));
      chk("ram_en", k, 32'(en_a[k]), 32'(exp_acc[k]));
      chk("ram_we", k, 32'(we_a[k]), (exp_acc[k] && wr) ? 32'(be_of(size, addr[1:0])) : 32'h0);
      if (exp_acc[k]) begin
        chk("ram_addr", k, 32'(ra_a[k]), 32'(addr[RamAw+1:2]));
        chk("ram_wdata", k, wd_a[k], wdata);
      end
      chk("data_ok", k, 32'(dok_a[k]), 32'(exp_pop[k]));
      chk("rdata", k, rdat_a[k], exp_rd);
    end
  endtask

  task automatic drive(input logic r, input logic q, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r; req = q; wr = w; size = s; addr = a; wdata = d;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hd[k] = 0;
        tl[k] = 0;
      end else begin
        if (exp_pop[k]) hd[k]++;
        if (exp_acc[k]) begin
          logic [31:0] d;
          logic [3:0]  m;
          d = 32'h0;
          if (wr) begin
            m = be_of(size, addr[1:0]);
            for (int b = 0; b < 4; b++)
              if (m[b]) ref_m[k][addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            d = ref_m[k][addr[7:2]];
          end
          rb[k][tl[k] % 16] = '{due: cyc + 2 + wait_of(k), data: d};
          tl[k]++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      tick();
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs [10];
  int   n_acc;
  int   n_resp;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    hd = '{0, 0}; tl = '{0, 0};
    exp_acc = '{1'b0, 1'b0}; exp_pop = '{1'b0, 1'b0};
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) ref_m[k][i] = init_word(i);
    tb_init = 1'b1;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;

    vecs[0] = '{1'b1, 2'd0, 32'h103, 32'hABABABAB, 4'b1000};
    vecs[1] = '{1'b1, 2'd1, 32'h102, 32'h12341234, 4'b1100};
    vecs[2] = '{1'b1, 2'd3, 32'h104, 32'hCAFEF00D, 4'b1111};
    vecs[3] = '{1'b1, 2'd0, 32'h100, 32'h11111111, 4'b0001};
    vecs[4] = '{1'b1, 2'd0, 32'h101, 32'h22222222, 4'b0010};
    vecs[5] = '{1'b1, 2'd1, 32'h109, 32'h33443344, 4'b0011};
    vecs[6] = '{1'b1, 2'd2, 32'h10F, 32'h55667788, 4'b1111};
    vecs[7] = '{1'b0, 2'd2, 32'h100, 32'hFFFFFFFF, 4'b0000};
    vecs[8] = '{1'b0, 2'd0, 32'h104, 32'h0, 4'b0000};
    vecs[9] = '{1'b0, 2'd1, 32'h10A, 32'h0, 4'b0000};

    // Reset with a request pending: everything held low.
    drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h10, 32'h0);
    tick();
    tb_init = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    chk("reset_addr_ok", 0, 32'(aok_a[0]), 32'h0);
    chk("reset_data_ok", 1, 32'(dok_a[1]), 32'h0);
    tick();
    idle(2);

    // Single read of word 4.
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    chk("rd10_addr_ok", 0, 32'(aok_a[0]), 32'h1);
    chk("rd10_ram_addr", 0, 32'(ra_a[0]), 32'h4);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("rd10_early", 0, 32'(dok_a[0]), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("rd10_data_ok", 0, 32'(dok_a[0]), 32'h1);
    chk("rd10_rdata", 0, rdat_a[0], 32'hDEADBEEF);
    tick();
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("rd10_w3_data_ok", 1, 32'(dok_a[1]), 32'h1);
    chk("rd10_w3_rdata", 1, rdat_a[1], 32'hDEADBEEF);
    tick();
    idle(4);

    // WAIT=3: back-to-back reads, third request held until a slot frees.
    for (int t = 0; t <= 6; t++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd2, (t == 0) ? 32'h20 : (t == 1) ? 32'h24 : 32'h28, 32'h0);
      if (t >= 2) chk("b2b_third_addr_ok", 1, 32'(aok_a[1]), (t == 6) ? 32'h1 : 32'h0);
      if (t == 5) chk("b2b_first_rdata", 1, rdat_a[1], init_word(8));
      if (t == 6) chk("b2b_second_rdata", 1, rdat_a[1], init_word(9));
      if (t >= 5) chk("b2b_data_ok", 1, 32'(dok_a[1]), 32'h1);
      tick();
    end
    idle(8);

    // Byte-enable table, each vector alone so both instances accept it.
    for (int v = 0; v < 10; v++) begin
      drive(1'b0, 1'b1, vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata);
      chk("tbl_we0", v, 32'(we_a[0]), 32'(vecs[v].exp_we));
      chk("tbl_we3", v, 32'(we_a[1]), 32'(vecs[v].exp_we));
      tick();
      idle(5);
    end

    // Reset with two reads outstanding: their responses must never appear.
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h30, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h34, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      chk("stale_data_ok0", 0, 32'(dok_a[0]), 32'h0);
      chk("stale_data_ok3", 1, 32'(dok_a[1]), 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
    tick();
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("post_rst_data_ok", 0, 32'(dok_a[0]), 32'h1);
    chk("post_rst_rdata", 0, rdat_a[0], init_word(16));
    tick();
    idle(6);

    // Continuous reads on the WAIT=0 instance; pointers wrap several times.
    n_acc = 0; n_resp = 0;
    for (int i = 0; i < 60 && n_resp < 10; i++) begin
      drive(1'b0, n_acc < 10, 1'b0, 2'd2, 32'h40 + 32'(4 * n_acc), 32'h0);
      if (aok_a[0]) n_acc++;
      if (dok_a[0]) n_resp++;
      tick();
    end
    chk("stream_resp_count", 0, 32'(n_resp), 32'd10);
    idle(8);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  s;
      logic [31:0] d;
      s = 2'($urandom_range(0, 3));
      d = $urandom;
      if (s == 2'd0) d = {4{d[7:0]}};
      else if (s == 2'd1) d = {2{d[15:0]}};
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4), s, $urandom, d);
      tick();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
